note_chart_sequencer: RTL and testbench

- Upstream stage of the per-lane note movers. Walks a song chart held in a synchronous ROM. Each entry carries a spawn frame and a lane mask.
- Counts frames from frame_clk. When an entry's frame is reached, emits a one-Clk-cycle trigger pulse to the next slot of each masked lane.
- Slots are allocated round-robin per lane; the trigger bus wires directly onto the lane modules' slot trigger inputs.

---
 rtl/note_chart_sequencer_pkg.sv | 24 ++
 rtl/note_chart_sequencer_frame_tick_sync.sv | 24 ++
 rtl/note_chart_sequencer.sv | 107 ++++++++++
 tb/tb_note_chart_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_chart_sequencer_pkg.sv
// Shared sizing and types for the note chart sequencer: chart word layout
// and sequencer states.
package note_chart_pkg;
  localparam int NUM_LANES   = 5;
  localparam int SLOTS       = 20;
  localparam int TICK_W      = 16;
  localparam int CHART_DEPTH = 256;
  localparam int ADDR_W      = $clog2(CHART_DEPTH);

  typedef struct packed {
    logic                 end_flag;
    logic [NUM_LANES-1:0] lane_mask;
    logic [TICK_W-1:0]    spawn_frame;
  } chart_entry_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    COMPARE = 3'd3,
    FIRE    = 3'd4,
    DONE    = 3'd5
  } seq_state_t;
endpackage

// File: rtl/note_chart_sequencer_frame_tick_sync.sv
// Brings the asynchronous frame clock into the Clk domain and turns each
// rising edge into a single-cycle frame_tick.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);
  logic sync_p0, sync_p1, sync_p2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= frame_clk;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign frame_tick = sync_p1 & ~sync_p2;
endmodule

// File: rtl/note_chart_sequencer.sv
// Walks the song chart ROM and pulses the next round-robin slot of each
// masked lane when the entry's spawn frame has been reached.
module note_chart_sequencer #(
  parameter int NUM_LANES   = note_chart_pkg::NUM_LANES,
  parameter int SLOTS       = note_chart_pkg::SLOTS,
  parameter int CHART_DEPTH = note_chart_pkg::CHART_DEPTH,
  parameter int ADDR_W      = note_chart_pkg::ADDR_W,
  parameter int TICK_W      = note_chart_pkg::TICK_W
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_clk,
  input  logic                         start,
  input  logic                         pause,
  output logic [ADDR_W-1:0]            chart_addr,
  input  logic [TICK_W+NUM_LANES:0]    chart_data,
  output logic [NUM_LANES*SLOTS-1:0]   trigger,
  output logic [TICK_W-1:0]            frame_count,
  output logic                         busy,
  output logic                         done
);
  import note_chart_pkg::*;

  localparam int PTR_W  = $clog2(SLOTS);
  localparam int TRIG_W = $clog2(NUM_LANES * SLOTS);

  seq_state_t       state;
  chart_entry_t     entry;
  logic [PTR_W-1:0] ptr [NUM_LANES];
  logic             frame_tick;
  logic             running;

  frame_tick_sync u_frame_tick_sync (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  assign running = (state == FETCH) || (state == WAIT) ||
                   (state == COMPARE) || (state == FIRE);
  assign busy    = running;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      chart_addr  <= '0;
      frame_count <= '0;
      done        <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) ptr[l] <= '0;
    end else begin
      if (running && !pause && frame_tick) frame_count <= frame_count + 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= FETCH;
            chart_addr  <= '0;
            frame_count <= '0;
            done        <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) ptr[l] <= '0;
          end
        end
        FETCH: state <= WAIT;
        WAIT:  state <= COMPARE;
        COMPARE: begin
          if (entry.end_flag) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (!pause && (entry.spawn_frame <= frame_count)) begin
            state <= FIRE;
          end
        end
        FIRE: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (entry.lane_mask[l])
              ptr[l] <= (ptr[l] == PTR_W'(SLOTS - 1)) ? '0 : ptr[l] + 1'b1;
          end
          // The chart never wraps: the last ROM word ends playback.
          if (chart_addr == ADDR_W'(CHART_DEPTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            chart_addr <= chart_addr + 1'b1;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ROM word lands during WAIT; entry holds it through COMPARE and FIRE
  always_ff @(posedge Clk) begin
    if (state == WAIT) entry <= chart_entry_t'(chart_data);
  end

  // Reset masks the pulse combinationally so an abort never leaks a trigger.
  always_comb begin
    trigger = '0;
    if ((state == FIRE) && !Reset) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (entry.lane_mask[l])
          trigger[TRIG_W'(l * SLOTS) + TRIG_W'(ptr[l])] = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_note_chart_sequencer.sv
// Bench for note_chart_sequencer: timestamp-based reference model checked every
// cycle, directed chart scenarios with literal expectations, random charts.
module tb_note_chart_sequencer;
  localparam int NL = 5, NS = 20, DEPTH = 256, AW = 8, TW = 16;
  localparam int DW = TW + NL + 1, TB = NL * NS;

  logic Clk = 0, Reset = 1, frame_clk = 0, start = 0, pause = 0;
  logic [AW-1:0] chart_addr;
  logic [DW-1:0] chart_data;
  logic [DW-1:0] rom [DEPTH];
  logic [TB-1:0] trigger;
  logic [TW-1:0] frame_count;
  logic busy, done;

  int checks = 0, errors = 0;

  note_chart_sequencer dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .pause(pause),
    .chart_addr(chart_addr), .chart_data(chart_data), .trigger(trigger),
    .frame_count(frame_count), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) chart_data <= rom[chart_addr];

  int fhalf = 4;
  initial forever begin
    repeat (fhalf) @(posedge Clk);
    #1 frame_clk = ~frame_clk;
  end

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] mk(bit e, logic [NL-1:0] m, int sp);
    return {e, m, TW'(sp)};
  endfunction

  // Reference model: each entry becomes comparable at m_cmp, fires the cycle
  // after its spawn frame is seen unpaused, and the next entry is comparable
  // three cycles after a fire.
  int cyc = 0;
  bit chk_en = 0;
  bit m_run = 0, m_done = 0;
  logic [TW-1:0] m_fc = '0;
  int m_addr = 0, m_cmp = 0, m_fire = -1;
  int m_ptr [NL] = '{default: 0};
  bit d0 = 0, d1 = 0, d2 = 0;
  int pulse_cnt = 0;
  int pulse_cyc [$];
  logic [TB-1:0] pulse_val [$];
  int watch_val = -1, watch_cyc = -1;

  always @(negedge Clk) begin
    logic [TB-1:0] exp_t;
    logic [DW-1:0] e;
    logic [TW-1:0] fc_n;
    bit tk;
    tk = d1 && !d2;
    exp_t = '0;
    if (m_run && cyc == m_fire && !Reset) begin
      e = rom[m_addr];
      for (int l = 0; l < NL; l++) if (e[TW+l]) exp_t[l*NS+m_ptr[l]] = 1'b1;
    end
    if (chk_en) begin
      chk("trigger", 128'(trigger), 128'(exp_t));
      chk("frame_count", 128'(frame_count), 128'(m_fc));
      chk("busy", 128'(busy), 128'(m_run));
      chk("done", 128'(done), 128'(m_done));
      chk("chart_addr", 128'(chart_addr), 128'(m_addr));
    end
    if (trigger !== '0) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      pulse_val.push_back(trigger);
    end
    if (busy === 1'b1 && watch_cyc < 0 && int'(frame_count) == watch_val) watch_cyc = cyc;

    if (Reset) begin
      m_run = 0; m_done = 0; m_fc = '0; m_addr = 0; m_fire = -1; m_cmp = 0;
      for (int l = 0; l < NL; l++) m_ptr[l] = 0;
      d0 = 0; d1 = 0; d2 = 0;
    end else begin
      fc_n = m_fc;
      if (m_run && tk && !pause) fc_n = m_fc + 1'b1;
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_done = 0; fc_n = '0; m_addr = 0; m_cmp = cyc + 3; m_fire = -1;
          for (int l = 0; l < NL; l++) m_ptr[l] = 0;
        end
      end else if (cyc == m_fire) begin
        e = rom[m_addr];
        for (int l = 0; l < NL; l++) if (e[TW+l]) m_ptr[l] = (m_ptr[l] + 1) % NS;
        m_fire = -1;
        if (m_addr == DEPTH - 1) begin
          m_run = 0; m_done = 1;
        end else begin
          m_addr++; m_cmp = cyc + 3;
        end
      end else if (m_fire < 0 && cyc >= m_cmp) begin
        e = rom[m_addr];
        if (e[DW-1]) begin
          m_run = 0; m_done = 1;
        end else if (!pause && e[TW-1:0] <= m_fc) begin
          m_fire = cyc + 1;
        end
      end
      m_fc = fc_n;
      d2 = d1; d1 = d0; d0 = frame_clk;
    end
    cyc++;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      step();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(1, '0, 0);
  endtask

  initial begin
    int base, sp, n;
    logic [TB-1:0] one, expv;
    one = 1;
    clear_rom();
    Reset = 1;
    repeat (3) @(posedge Clk);
    #1;
    chk_en = 1;
    Reset = 0;
    chk("rst_addr", 128'(chart_addr), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_trigger", 128'(trigger), 0);
    chk("rst_fc", 128'(frame_count), 0);
    step();

    // single lane-0 note at frame 3
    rom[0] = mk(0, 5'b00001, 3); rom[1] = mk(1, '0, 0);
    base = pulse_cnt; watch_val = 3; watch_cyc = -1;
    pulse_start();
    wait_idle(2000);
    step();
    chk("t1_count", 128'(pulse_cnt - base), 1);
    chk("t1_value", 128'(pulse_val[base]), 128'(1));
    chk("t1_latency", 128'(pulse_cyc[base]), 128'(watch_cyc + 1));
    chk("t1_done", 128'(done), 1);
    chk("t1_busy", 128'(busy), 0);

    // 21 past-due entries on lane 2: back-to-back, pointer wraps
    clear_rom();
    for (int i = 0; i < 21; i++) rom[i] = mk(0, 5'b00100, 0);
    base = pulse_cnt;
    pulse_start();
    repeat (10) step();
    pulse_start();
    wait_idle(2000);
    chk("t2_count", 128'(pulse_cnt - base), 21);
    for (int k = 0; k < 21 && base + k < pulse_val.size(); k++) begin
      expv = one << (40 + k % 20);
      chk("t2_bit", 128'(pulse_val[base+k]), 128'(expv));
      if (k > 0) chk("t2_gap", 128'(pulse_cyc[base+k] - pulse_cyc[base+k-1]), 4);
    end

    // all lanes at once, twice
    clear_rom();
    rom[0] = mk(0, 5'b11111, 2); rom[1] = mk(0, 5'b11111, 2);
    base = pulse_cnt;
    pulse_start();
    wait_idle(2000);
    chk("t3_count", 128'(pulse_cnt - base), 2);
    if (pulse_cnt - base >= 2) begin
      expv = (one << 0) | (one << 20) | (one << 40) | (one << 60) | (one << 80);
      chk("t3_first", 128'(pulse_val[base]), 128'(expv));
      chk("t3_second", 128'(pulse_val[base+1]), 128'(expv << 1));
    end

    // pause freezes the frame counter across the spawn frame
    clear_rom();
    rom[0] = mk(0, 5'b00001, 5);
    base = pulse_cnt;
    pulse_start();
    n = 0;
    while (frame_count !== 16'd4 && n < 2000) begin step(); n++; end
    pause = 1;
    repeat (60) step();
    chk("t4_frozen", 128'(frame_count), 4);
    chk("t4_nopulse", 128'(pulse_cnt - base), 0);
    watch_val = 5; watch_cyc = -1;
    pause = 0;
    wait_idle(2000);
    chk("t4_count", 128'(pulse_cnt - base), 1);
    if (pulse_cnt > base) chk("t4_latency", 128'(pulse_cyc[base]), 128'(watch_cyc + 1));

    // reset in the firing cycle aborts cleanly, then replay from address 0
    clear_rom();
    rom[0] = mk(0, 5'b00001, 0);
    base = pulse_cnt;
    pulse_start();
    repeat (3) step();
    Reset = 1;
    step();
    Reset = 0;
    chk("t5_nopulse", 128'(pulse_cnt - base), 0);
    chk("t5_busy", 128'(busy), 0);
    chk("t5_addr", 128'(chart_addr), 0);
    chk("t5_fc", 128'(frame_count), 0);
    chk("t5_done", 128'(done), 0);
    step();
    pulse_start();
    wait_idle(2000);
    chk("t5_replay", 128'(pulse_cnt - base), 1);
    if (pulse_cnt > base) chk("t5_replay_val", 128'(pulse_val[base]), 128'(1));

    // full chart with no end flag stops at the last address
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(0, 5'b00010, 0);
    base = pulse_cnt;
    pulse_start();
    for (int i = 0; i < 5; i++) begin repeat (37) step(); pulse_start(); end
    wait_idle(3000);
    chk("t6_count", 128'(pulse_cnt - base), 256);
    chk("t6_addr", 128'(chart_addr), 255);
    chk("t6_done", 128'(done), 1);
    expv = one << (20 + 255 % 20);
    chk("t6_last", 128'(pulse_val[pulse_val.size()-1]), 128'(expv));

    // random charts with random pause and stray starts
    for (int it = 0; it < 4; it++) begin
      clear_rom();
      n = $urandom_range(5, 30);
      sp = 0;
      for (int i = 0; i < n; i++) begin
        sp += $urandom_range(0, 3);
        rom[i] = mk(0, NL'($urandom_range(0, 31)), sp);
      end
      fhalf = $urandom_range(2, 5);
      pulse_start();
      for (int c = 0; c < 8000; c++) begin
        step();
        if (busy !== 1'b1) break;
        if ($urandom_range(0, 9) == 0) pause = ~pause;
        start = ($urandom_range(0, 29) == 0);
      end
      start = 0;
      pause = 0;
      wait_idle(3000);
      chk("rand_done", 128'(done), 1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
